// File: rtl/mem_responder.sv
// mem_responder: instruction/data memories for seq_core with a stream-fed program loader
// that holds the core in reset until the program has been loaded.
module mem_responder #(
  parameter int          A_SIZE     = 10,
  parameter int          D_SIZE     = 32,
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [15:0] FILL_INSTR = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [15:0]       load_data,
  input  logic              load_last,
  input  logic              reload,
  output logic              core_rst,
  input  logic [A_SIZE-1:0] pc,
  output logic [15:0]       instruction,
  input  logic              read,
  input  logic              write,
  input  logic [A_SIZE-1:0] address,
  input  logic [D_SIZE-1:0] data_out,
  output logic [D_SIZE-1:0] data_in,
  output logic              err,
  output logic [A_SIZE:0]   loaded_cnt
);
  typedef enum logic {LOAD, RUN} state_t;
  localparam int IAW = IMEM_DEPTH > 1 ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = DMEM_DEPTH > 1 ? $clog2(DMEM_DEPTH) : 1;
  logic [15:0]       r_imem [IMEM_DEPTH];
  logic [D_SIZE-1:0] r_dmem [DMEM_DEPTH];
  state_t            r_state, w_next;
  logic              r_load_ready, r_core_rst, r_err;
  logic [A_SIZE:0]   r_cnt;
  logic              w_accept, w_run, w_daddr_ok, w_pc_ok, w_last_slot;
  assign w_accept    = load_valid & r_load_ready;
  assign w_run       = r_state == RUN;
  assign w_daddr_ok  = 32'(address) < DMEM_DEPTH;
  assign w_pc_ok     = 32'(pc) < IMEM_DEPTH;
  assign w_last_slot = 32'(r_cnt) == IMEM_DEPTH - 1;
  always_comb begin
    w_next = r_state;
    if (r_state == LOAD)
      w_next = (w_accept && (load_last || w_last_slot)) ? RUN : LOAD;
    else
      w_next = reload ? LOAD : RUN;
  end
  // Handshake and core reset are registered from the next state so both flip on the final accept edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= LOAD;
      r_load_ready <= 1'b0;
      r_core_rst   <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_next;
      r_load_ready <= w_next == LOAD;
      r_core_rst   <= w_next == RUN;
      if (w_run && reload) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        if (w_accept && 32'(r_cnt) < IMEM_DEPTH) r_cnt <= r_cnt + 1'b1;
        if (w_run && (((read | write) && !w_daddr_ok) || !w_pc_ok)) r_err <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst && w_accept) r_imem[r_cnt[IAW-1:0]] <= load_data;
    if (rst && w_run && write && w_daddr_ok) r_dmem[address[DAW-1:0]] <= data_out;
  end
  assign instruction = ({1'b0, pc} < r_cnt) ? r_imem[pc[IAW-1:0]] : FILL_INSTR;
  assign data_in     = (w_run && read && w_daddr_ok) ? r_dmem[address[DAW-1:0]] : '0;
  assign load_ready  = r_load_ready;
  assign core_rst    = r_core_rst;
  assign err         = r_err;
  assign loaded_cnt  = r_cnt;
endmodule
